uart_rx_frame_ctrl: RTL

Frame-level controller that sits behind the UART receiver and owns its configuration. It drives the receiver's 32-bit baud divider, consumes the receiver's per-byte strobe, and assembles bytes into checksummed frames. Validated data frames are buffered and streamed to the downstream logic over a valid/ready interface. Validated baud-command frames reprogram the receiver's divider.

---
 rtl/uart_rx_frame_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
//   Frame-level controller behind the UART receiver. Owns the receiver's baud
//   divider, assembles received bytes into SOF/LEN/CMD/payload/CHK frames,
//   streams validated data payloads downstream over valid/ready and applies
//   validated baud-command frames to the divider.
//
// Ports
//   clk_input, rst_input : clock (rising edge) and asynchronous active-high reset
//   rx_data, rx_complete : received byte and its active-low one-cycle strobe
//   baud_rate            : divider fed to the receiver
//   pl_data/pl_valid/pl_ready/pl_last/pl_cmd : payload stream of a data frame
//   frame_ok, frame_err  : one-cycle status pulses
//   err_code             : 0 checksum, 1 length, 2 timeout, 3 overrun
module uart_rx_frame_ctrl #(
   parameter logic [31:0] DEFAULT_BAUD_DIV = 32'd434,
   parameter int unsigned MAX_PAYLOAD      = 16,
   parameter logic [31:0] TIMEOUT_CYCLES   = 32'd50000,
   parameter logic [7:0]  SOF_BYTE         = 8'hAA
) (
   input  logic        clk_input,
   input  logic        rst_input,
   input  logic [7:0]  rx_data,
   input  logic        rx_complete,
   output logic [31:0] baud_rate,
   output logic [7:0]  pl_data,
   output logic        pl_valid,
   input  logic        pl_ready,
   output logic        pl_last,
   output logic [7:0]  pl_cmd,
   output logic        frame_ok,
   output logic        frame_err,
   output logic [1:0]  err_code
);

   localparam int unsigned IDX_W    = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
   localparam int unsigned DEPTH    = 1 << IDX_W;
   localparam logic [7:0]  MAX_LEN  = 8'(MAX_PAYLOAD);
   localparam logic [7:0]  CMD_BAUD = 8'h01;

   typedef enum logic [2:0] {IDLE, GET_LEN, GET_CMD, GET_PL, GET_CHK, DRAIN} state_t;

   state_t             state, state_nx;
   logic               ev;
   logic [7:0]         len, cmd, chk;
   logic [IDX_W-1:0]   idx;
   logic [31:0]        tcnt;
   logic [31:0]        word;
   logic [7:0]         mem [DEPTH];
   logic               in_frame, timed_out, at_last;
   logic               ok_nx, err_nx;
   logic [1:0]         code_nx;

   assign ev        = ~rx_complete;
   assign in_frame  = (state == GET_LEN) || (state == GET_CMD) ||
                      (state == GET_PL)  || (state == GET_CHK);
   // The Nth consecutive idle clock is the one that would bring the count to N.
   assign timed_out = in_frame && !ev && (tcnt == TIMEOUT_CYCLES - 32'd1);
   // idx is the write pointer while receiving and the read pointer while draining.
   assign at_last   = (8'(idx) == len - 8'd1);

   assign pl_valid  = (state == DRAIN);
   assign pl_last   = pl_valid && at_last;
   assign pl_data   = pl_valid ? mem[idx] : '0;

   always_comb begin
      state_nx = state;
      ok_nx    = 1'b0;
      err_nx   = 1'b0;
      code_nx  = err_code;
      case (state)
         IDLE: if (ev && rx_data == SOF_BYTE) state_nx = GET_LEN;
         GET_LEN: if (ev) begin
            if (rx_data == 8'd0 || rx_data > MAX_LEN) begin
               err_nx   = 1'b1;
               code_nx  = 2'd1;
               state_nx = IDLE;
            end else begin
               state_nx = GET_CMD;
            end
         end
         GET_CMD: if (ev) begin
            if (rx_data == CMD_BAUD && len != 8'd4) begin
               err_nx   = 1'b1;
               code_nx  = 2'd1;
               state_nx = IDLE;
            end else begin
               state_nx = GET_PL;
            end
         end
         GET_PL: if (ev && at_last) state_nx = GET_CHK;
         GET_CHK: if (ev) begin
            state_nx = IDLE;
            if (rx_data != chk) begin
               err_nx  = 1'b1;
               code_nx = 2'd0;
            end else begin
               ok_nx = 1'b1;
               if (cmd != CMD_BAUD) state_nx = DRAIN;
            end
         end
         DRAIN: begin
            // Bytes arriving while draining are dropped; the stream is unaffected.
            if (ev) begin
               err_nx  = 1'b1;
               code_nx = 2'd3;
            end
            if (pl_ready && at_last) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (timed_out) begin
         state_nx = IDLE;
         err_nx   = 1'b1;
         code_nx  = 2'd2;
      end
   end

   always_ff @(posedge clk_input or posedge rst_input) begin
      if (rst_input) state <= IDLE;
      else           state <= state_nx;
   end

   always_ff @(posedge clk_input or posedge rst_input) begin
      if (rst_input) begin
         len       <= '0;
         cmd       <= '0;
         chk       <= '0;
         idx       <= '0;
         tcnt      <= '0;
         word      <= '0;
         baud_rate <= DEFAULT_BAUD_DIV;
         pl_cmd    <= '0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= '0;
      end else begin
         frame_ok  <= ok_nx;
         frame_err <= err_nx;
         err_code  <= code_nx;
         if (ev || !in_frame || timed_out) tcnt <= '0;
         else                              tcnt <= tcnt + 32'd1;
         case (state)
            GET_LEN: if (ev) begin
               len <= rx_data;
               chk <= rx_data;
            end
            GET_CMD: if (ev) begin
               cmd <= rx_data;
               chk <= chk ^ rx_data;
               idx <= '0;
            end
            GET_PL: if (ev) begin
               chk  <= chk ^ rx_data;
               // Last four payload bytes, big-endian, for the baud command.
               word <= {word[23:0], rx_data};
               idx  <= idx + IDX_W'(1);
            end
            GET_CHK: if (ok_nx) begin
               if (cmd == CMD_BAUD) begin
                  baud_rate <= word;
               end else begin
                  pl_cmd <= cmd;
                  idx    <= '0;
               end
            end
            DRAIN: if (pl_ready) idx <= idx + IDX_W'(1);
            default: ;
         endcase
      end
   end

   // Payload store; contents after reset are irrelevant, so it has no reset.
   always_ff @(posedge clk_input) begin
      if (state == GET_PL && ev) mem[idx] <= rx_data;
   end

endmodule
